hex_entry: RTL and testbench

- User-input counterpart of the counter-to-hex-display path.
- Captures hex digits from slide switches, one per push-button press, and assembles them MSD-first into a word of NDIG nibbles.
- Presents the word with a valid/accept handshake so downstream logic (loadable counter, comparator) can consume it.
- Drives a per-digit blank mask so the display shows only digits entered so far.

---
 rtl/hex_entry_pkg.sv | 6 +
 rtl/key_debounce.sv | 31 +++
 rtl/hex_entry.sv | 60 ++++++
 tb/tb_hex_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared types and constants for the hex digit entry path.
package hex_entry_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_FULL} state_e;
  localparam int DIG_W = 4;
  localparam int DEB_CYCLES_DEF = 4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key, emits a one-cycle press event.
module key_debounce import hex_entry_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic sync1_q, sync2_q, deb_q, press_q, flip;
  logic [CW-1:0] cnt_q;
  // The level flips on the cycle the counter would reach DEB_CYCLES.
  assign flip = (sync2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= (sync2_q == deb_q || flip) ? '0 : cnt_q + 1'b1;
      deb_q   <= flip ? sync2_q : deb_q;
      press_q <= flip && !sync2_q;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/hex_entry.sv
// hex_entry: assembles debounced key presses into an NDIG-nibble word with valid/accept handshake.
module hex_entry import hex_entry_pkg::*; #(
  parameter int NDIG = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                       clock,
  input  logic                       Resetn,
  input  logic                       key_n,
  input  logic [DIG_W-1:0]           digit,
  input  logic                       clear_entry,
  input  logic                       accept,
  output logic [DIG_W*NDIG-1:0]      Q,
  output logic [$clog2(NDIG+1)-1:0]  count,
  output logic                       valid,
  output logic [NDIG-1:0]            blank,
  output logic                       ovf
);
  localparam int W = DIG_W * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  state_e state_q;
  logic [W-1:0] q_q, q_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, press;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clock  (clock),
    .Resetn (Resetn),
    .key_n  (key_n),
    .press  (press)
  );
  assign q_d = (q_q << DIG_W) | W'(digit);
  assign count_d = count_q + 1'b1;
  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (clear_entry || (accept && state_q == ST_FULL)) begin
        state_q <= ST_IDLE;
        q_q     <= '0;
        count_q <= '0;
      end else if (press && state_q == ST_FULL) begin
        ovf_q <= 1'b1;
      end else if (press) begin
        q_q     <= q_d;
        count_q <= count_d;
        state_q <= (count_d == CW'(NDIG)) ? ST_FULL : ST_ENTRY;
      end
    end
  end
  assign Q = q_q;
  assign count = count_q;
  assign ovf = ovf_q;
  assign valid = state_q == ST_FULL;
  for (genvar i = 0; i < NDIG; i++) begin : g_blank
    assign blank[i] = CW'(i) >= count_q;
  end
endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: table vectors, corner sequences and randomized key traffic against a word/count model.
module tb_hex_entry;
  localparam int NDIG = 4;
  localparam int DEB = 4;
  localparam int W = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  logic clock = 1'b0, Resetn = 1'b1, key_n = 1'b1, clear_entry = 1'b0, accept = 1'b0;
  logic [3:0] digit = 4'h0;
  logic [W-1:0] Q;
  logic [CW-1:0] count;
  logic valid, ovf;
  logic [NDIG-1:0] blank;

  hex_entry #(.NDIG(NDIG), .DEB_CYCLES(DEB)) dut (
    .clock       (clock),
    .Resetn      (Resetn),
    .key_n       (key_n),
    .digit       (digit),
    .clear_entry (clear_entry),
    .accept      (accept),
    .Q           (Q),
    .count       (count),
    .valid       (valid),
    .blank       (blank),
    .ovf         (ovf)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int e = 0, pend = -1, chg_edge = 0, ovf_cnt = 0;
  logic [W-1:0] m_w = '0;
  int m_c = 0;
  logic m_ovf = 1'b0;

  typedef struct {
    logic [3:0]      d;
    logic [W-1:0]    q;
    int              c;
    logic            v;
    logic [NDIG-1:0] b;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model();
    logic [NDIG-1:0] b;
    b = '1;
    b = b << m_c;
    chk("Q", 64'(Q), 64'(m_w));
    chk("count", 64'(count), 64'(m_c));
    chk("valid", 64'(valid), 64'(m_c == NDIG));
    chk("blank", 64'(blank), 64'(b));
    chk("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  // One clock: drive at negedge, advance model at the edge, compare at the next negedge.
  task automatic cyc(input logic k, input logic [3:0] d, input logic clr, input logic acc);
    logic [CW-1:0] prev;
    key_n = k;
    digit = d;
    clear_entry = clr;
    accept = acc;
    prev = count;
    @(posedge clock);
    e++;
    m_ovf = 1'b0;
    if (clr) begin
      m_w = '0;
      m_c = 0;
    end else if (acc && m_c == NDIG) begin
      m_w = '0;
      m_c = 0;
    end else if (e == pend) begin
      if (m_c == NDIG) m_ovf = 1'b1;
      else begin
        m_w = (m_w << 4) | W'(d);
        m_c++;
      end
    end
    @(negedge clock);
    if (count !== prev) chg_edge = e;
    if (ovf === 1'b1) ovf_cnt++;
    chk_model();
  endtask

  // Key held low for 'low' cycles then high for 'gap'; accept/clear pulsed at relative cycle.
  task automatic pulse(input logic [3:0] d, input int low, input int gap,
                       input int acc_at, input int clr_at, output int e0);
    e0 = e + 1;
    if (low >= DEB) pend = e0 + DEB + 2;
    for (int k = 1; k <= low + gap; k++)
      cyc(k > low, d, k == clr_at, k == acc_at);
  endtask

  task automatic do_reset();
    #2 Resetn = 1'b0;
    #1;
    chk("rst_Q", 64'(Q), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_blank", 64'(blank), 64'({NDIG{1'b1}}));
    chk("rst_ovf", 64'(ovf), 64'(0));
    m_w = '0;
    m_c = 0;
    m_ovf = 1'b0;
    pend = -1;
    key_n = 1'b1;
    clear_entry = 1'b0;
    accept = 1'b0;
    @(negedge clock);
    @(negedge clock);
    Resetn = 1'b1;
  endtask

  int e0, low, gap;
  logic [3:0] rd;

  initial begin
    tbl[0] = '{4'hA, 16'h000A, 1, 1'b0, 4'b1110};
    tbl[1] = '{4'hB, 16'h00AB, 2, 1'b0, 4'b1100};
    tbl[2] = '{4'hC, 16'h0ABC, 3, 1'b0, 4'b1000};
    tbl[3] = '{4'hD, 16'hABCD, 4, 1'b1, 4'b0000};
    @(negedge clock);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      pulse(tbl[i].d, DEB + 2, DEB + 4, 0, 0, e0);
      chk("latency", 64'(chg_edge - e0 + 1), 64'(3 + DEB));
      chk("tbl_Q", 64'(Q), 64'(tbl[i].q));
      chk("tbl_count", 64'(count), 64'(tbl[i].c));
      chk("tbl_valid", 64'(valid), 64'(tbl[i].v));
      chk("tbl_blank", 64'(blank), 64'(tbl[i].b));
    end

    ovf_cnt = 0;
    pulse(4'h1, DEB + 2, DEB + 4, 0, 0, e0);
    chk("ovf_pulses", 64'(ovf_cnt), 64'(1));
    chk("ovf_Q", 64'(Q), 64'(16'hABCD));
    cyc(1'b1, 4'h0, 1'b0, 1'b1);
    chk("acc_Q", 64'(Q), 64'(0));
    chk("acc_count", 64'(count), 64'(0));
    chk("acc_valid", 64'(valid), 64'(0));
    chk("acc_blank", 64'(blank), 64'(4'b1111));

    for (int r = 0; r < 5; r++) pulse(4'h5, DEB - 1, DEB + 2, 0, 0, e0);
    chk("bounce_Q", 64'(Q), 64'(0));
    chk("bounce_count", 64'(count), 64'(0));
    pulse(4'h7, DEB, DEB + 4, 0, 0, e0);
    chk("stable_count", 64'(count), 64'(1));
    chk("stable_Q", 64'(Q), 64'(16'h0007));

    pulse(4'h8, DEB + 2, DEB + 4, 0, 0, e0);
    pulse(4'h9, DEB + 2, DEB + 4, 0, 0, e0);
    pulse(4'hA, DEB + 2, DEB + 4, 0, 0, e0);
    chk("full_Q", 64'(Q), 64'(16'h789A));
    ovf_cnt = 0;
    pulse(4'h3, DEB + 2, DEB + 4, DEB + 3, 0, e0);
    chk("accpress_Q", 64'(Q), 64'(0));
    chk("accpress_count", 64'(count), 64'(0));
    chk("accpress_ovf", 64'(ovf_cnt), 64'(0));

    pulse(4'h1, DEB + 2, DEB + 4, 0, 0, e0);
    pulse(4'h2, DEB + 2, DEB + 4, 0, 0, e0);
    chk("entry2_count", 64'(count), 64'(2));
    pulse(4'h3, DEB + 2, DEB + 4, 0, DEB + 3, e0);
    chk("clrpress_Q", 64'(Q), 64'(0));
    chk("clrpress_count", 64'(count), 64'(0));
    chk("clrpress_ovf", 64'(ovf_cnt), 64'(0));

    pulse(4'h6, 100, DEB + 2, 0, 0, e0);
    chk("held_count", 64'(count), 64'(1));
    chk("held_Q", 64'(Q), 64'(16'h0006));

    pulse(4'h4, DEB + 2, DEB + 4, 0, 0, e0);
    cyc(1'b0, 4'h5, 1'b0, 1'b0);
    cyc(1'b0, 4'h5, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < DEB + 4; i++) cyc(1'b1, 4'h5, 1'b0, 1'b0);
    chk("post_rst_count", 64'(count), 64'(0));

    for (int s = 0; s < 60; s++) begin
      rd = 4'($urandom);
      low = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEB - 1)) : int'($urandom_range(DEB, DEB + 5));
      gap = int'($urandom_range(DEB + 2, DEB + 8));
      e0 = e + 1;
      if (low >= DEB) pend = e0 + DEB + 2;
      for (int k = 1; k <= low + gap; k++)
        cyc(k > low, rd, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
